// File: rtl/imm_pkg.sv
// Immediate-format encodings shared by the immediate generator and the control unit.
package imm_pkg;
  typedef logic [2:0] imm_type_t;

  localparam imm_type_t IMM_I = 3'b000;
  localparam imm_type_t IMM_S = 3'b001;
  localparam imm_type_t IMM_B = 3'b010;
  localparam imm_type_t IMM_U = 3'b011;
  localparam imm_type_t IMM_J = 3'b100;
  localparam imm_type_t IMM_Z = 3'b101;
endpackage

// File: rtl/imm_extract.sv
// Combinational RV immediate extraction: builds a 32-bit value, then sign-extends it to XLEN.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  input  imm_type_t       imm_type,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);
  logic [31:0] raw;

  // Z is zero-extended into raw, so bit 31 is 0 and the final sign-extension is harmless.
  always_comb begin
    raw     = '0;
    illegal = 1'b0;
    case (imm_type)
      IMM_I:   raw = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   raw = {instr[31:12], 12'b0};
      IMM_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_Z:   raw = {27'b0, instr[19:15]};
      default: illegal = 1'b1;
    endcase
  end

  assign imm = XLEN'($signed(raw));
endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: extracts on entry, buffers {imm, tag, illegal} in a 2-deep skid queue.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  imm_type_t        in_imm_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);
  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  entry_t          mem [2];
  entry_t          last_q;
  entry_t          head;
  entry_t          in_ent;
  logic            wr_ptr, rd_ptr;
  logic [1:0]      count;
  logic            push, pop;
  logic [XLEN-1:0] ext_imm;
  logic            ext_ill;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr    (in_instr),
    .imm_type (in_imm_type),
    .imm      (ext_imm),
    .illegal  (ext_ill)
  );

  assign in_ready  = ~count[1];
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign in_ent    = '{imm: ext_imm, tag: in_tag, illegal: ext_ill};

  // When empty, outputs show the last popped entry rather than a stale slot.
  assign head        = out_valid ? mem[rd_ptr] : last_q;
  assign out_imm     = head.imm;
  assign out_tag     = head.tag;
  assign out_illegal = head.illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      last_q <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_ent;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=64 instance with a scoreboard, XLEN=32 instance with direct checks.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready, in_ready, out_valid, out_illegal;
  logic [31:0] in_instr;
  imm_type_t   in_imm_type;
  logic [63:0] in_tag, out_imm, out_tag;

  logic        flush_b, in_valid_b, out_ready_b, in_ready_b, out_valid_b, out_illegal_b;
  logic [31:0] in_instr_b, out_imm_b;
  imm_type_t   in_imm_type_b;
  logic [63:0] in_tag_b, out_tag_b;

  imm_gen_pipe #(.XLEN(64), .TAG_W(64)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_imm_type(in_imm_type), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_tag(out_tag), .out_illegal(out_illegal)
  );

  imm_gen_pipe #(.XLEN(32), .TAG_W(64)) dut32 (
    .clk(clk), .rst(rst), .flush(flush_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_instr(in_instr_b), .in_imm_type(in_imm_type_b), .in_tag(in_tag_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_imm(out_imm_b),
    .out_tag(out_tag_b), .out_illegal(out_illegal_b)
  );

  typedef struct {
    logic [31:0] instr;
    imm_type_t   ty;
    logic [63:0] imm;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [63:0] imm;
    logic [63:0] tag;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_pop = 0;
  vec_t v64[12];
  vec_t v32[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Pops are compared at the falling edge, ahead of the rising edge that performs them.
  always @(negedge clk) begin
    if (rst || flush) sb.delete();
    else if (out_valid && out_ready) begin
      n_pop++;
      if (sb.size() == 0) chk("unexpected pop", 64'd1, 64'd0);
      else begin
        mon_e = sb.pop_front();
        chk("pop imm", out_imm, mon_e.imm);
        chk("pop tag", out_tag, mon_e.tag);
        chk("pop illegal", 64'(out_illegal), 64'(mon_e.ill));
      end
    end
  end

  task automatic push64(input logic [31:0] ins, input imm_type_t ty, input logic [63:0] tg,
                        input logic [63:0] ei, input logic el);
    int   w = 0;
    logic rdy;
    in_valid = 1'b1; in_instr = ins; in_imm_type = ty; in_tag = tg;
    @(negedge clk);
    rdy = in_ready;
    while (!rdy && w < 50) begin
      @(negedge clk);
      rdy = in_ready;
      w++;
    end
    chk("push accepted", 64'(rdy), 64'd1);
    @(posedge clk);
    if (rdy) sb.push_back('{imm: ei, tag: tg, ill: el});
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 40) begin
      @(posedge clk);
      w++;
    end
    #1 chk("drain empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    v64[0]  = '{32'hFFF01013, IMM_I,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    v64[1]  = '{32'hFFF12037, IMM_U,  64'hFFFF_FFFF_FFF1_2000, 1'b0};
    v64[2]  = '{32'h0001D073, IMM_Z,  64'd3,                   1'b0};
    v64[3]  = '{32'hFFFFFFFF, 3'b111, 64'd0,                   1'b1};
    v64[4]  = '{32'h12345678, 3'b110, 64'd0,                   1'b1};
    v64[5]  = '{32'h02000100, IMM_S,  64'h22,                  1'b0};
    v64[6]  = '{32'hFE000FA3, IMM_S,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    v64[7]  = '{32'h00000263, IMM_B,  64'd4,                   1'b0};
    v64[8]  = '{32'h801FF06F, IMM_J,  64'hFFFF_FFFF_FFFF_F800, 1'b0};
    v64[9]  = '{32'h7FF00013, IMM_I,  64'h7FF,                 1'b0};
    v64[10] = '{32'h7FFFF037, IMM_U,  64'h0000_0000_7FFF_F000, 1'b0};
    v64[11] = '{32'h80000063, IMM_B,  64'hFFFF_FFFF_FFFF_F000, 1'b0};

    v32[0] = '{32'h801FF06F, IMM_J,  64'hFFFF_F800, 1'b0};
    v32[1] = '{32'hFFF12037, IMM_U,  64'hFFF1_2000, 1'b0};
    v32[2] = '{32'h00000263, IMM_B,  64'd4,         1'b0};
    v32[3] = '{32'hFFF01013, IMM_I,  64'hFFFF_FFFF, 1'b0};
    v32[4] = '{32'h0001D073, IMM_Z,  64'd3,         1'b0};
    v32[5] = '{32'hFFFFFFFF, 3'b110, 64'd0,         1'b1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_imm_type = IMM_I; in_tag = '0;
    flush_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b1;
    in_instr_b = '0; in_imm_type_b = IMM_I; in_tag_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_imm", out_imm, 64'd0);
    chk("reset out_tag", out_tag, 64'd0);
    chk("reset out_illegal", 64'(out_illegal), 64'd0);

    // Back-to-back stream with out_ready high: exercises simultaneous push/pop at count 1.
    for (int i = 0; i < 12; i++) begin
      push64(v64[i].instr, v64[i].ty, 64'h100 + 64'(i), v64[i].imm, v64[i].ill);
      chk("latency out_valid", 64'(out_valid), 64'd1);
    end
    drain();
    chk("table pop count", 64'(n_pop), 64'd12);
    chk("empty out_valid", 64'(out_valid), 64'd0);
    chk("empty holds imm", out_imm, 64'hFFFF_FFFF_FFFF_F000);
    chk("empty holds tag", out_tag, 64'h10B);

    // Backpressure: third entry must wait upstream, then all three drain in order.
    out_ready = 1'b0;
    n_pop = 0;
    push64(32'h00100013, IMM_I, 64'd1, 64'd1, 1'b0);
    push64(32'h00200013, IMM_I, 64'd2, 64'd2, 1'b0);
    chk("full in_ready", 64'(in_ready), 64'd0);
    chk("full out_tag head", out_tag, 64'd1);
    fork
      push64(32'h00300013, IMM_I, 64'd3, 64'd3, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("held in_ready", 64'(in_ready), 64'd0);
        chk("held out_tag", out_tag, 64'd1);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("backpressure pop count", 64'(n_pop), 64'd3);

    // Flush with a full queue and a same-cycle input: everything is dropped.
    out_ready = 1'b0;
    push64(32'h00500013, IMM_I, 64'h21, 64'd5, 1'b0);
    push64(32'h00600013, IMM_I, 64'h22, 64'd6, 1'b0);
    n_pop = 0;
    in_valid = 1'b1; in_instr = 32'h00700013; in_tag = 64'h23; flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    chk("flush out_valid", 64'(out_valid), 64'd0);
    chk("flush in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk("flush nothing emitted", 64'(out_valid), 64'd0);
    end
    chk("flush pop count", 64'(n_pop), 64'd0);

    // Reset mid-stream (with flush and input also asserted) clears the data outputs too.
    out_ready = 1'b0;
    push64(32'hFFF00013, IMM_I, 64'h31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    push64(32'hFFFFFFFF, 3'b111, 64'h32, 64'd0, 1'b1);
    chk("pre-reset out_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    in_valid = 1'b1; in_tag = 64'h33; flush = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_imm", out_imm, 64'd0);
    chk("rst out_tag", out_tag, 64'd0);
    chk("rst out_illegal", 64'(out_illegal), 64'd0);
    out_ready = 1'b1;
    push64(32'h02000100, IMM_S, 64'h41, 64'h22, 1'b0);
    drain();

    // XLEN=32 instance: one-cycle latency and 32-bit extension.
    for (int i = 0; i < 6; i++) begin
      in_valid_b = 1'b1; in_instr_b = v32[i].instr; in_imm_type_b = v32[i].ty;
      in_tag_b = 64'h300 + 64'(i);
      @(posedge clk);
      #1 in_valid_b = 1'b0;
      chk("x32 out_valid", 64'(out_valid_b), 64'd1);
      chk("x32 out_imm", 64'(out_imm_b), v32[i].imm);
      chk("x32 out_tag", out_tag_b, 64'h300 + 64'(i));
      chk("x32 out_illegal", 64'(out_illegal_b), 64'(v32[i].ill));
    end
    @(posedge clk);
    #1 chk("x32 drained", 64'(out_valid_b), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
